// File: rtl/uart_pkg.sv
// Shared UART frame constants and receiver FSM state encoding.
// Also used by the transmitter, so keep values in sync with it.
package uart_pkg;
  localparam int       OVERSAMPLE  = 16;
  localparam int       DATA_BITS   = 8;
  localparam logic     PARITY_SEED = 1'b1;
  localparam logic [3:0] TICK_MAX  = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rcv_state_e;
endpackage

// File: rtl/uart_rcv_if.sv
// Serial line, host read strobe and received-byte status between the receiver and the host.
interface uart_rcv_if;
  import uart_pkg::*;
  logic                 sdi;
  logic                 rdn;
  logic [DATA_BITS-1:0] dout;
  logic                 data_ready;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun;

  modport slave  (input sdi, rdn, output dout, data_ready, parity_error, framing_error, overrun);
  modport master (output sdi, rdn, input dout, data_ready, parity_error, framing_error, overrun);
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an idle-high asynchronous input, plus a one-cycle
// pulse on each high-to-low transition of the synchronized value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign fall_o = prev_q & ~sync_q[STAGES-1];
endmodule

// File: rtl/uart_rcv.sv
// 16x-oversampled UART receiver: start, d7..d0, odd parity, stop.
// Latches the byte and error flags per frame; host acks with a falling rdn edge.
module uart_rcv
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_PT   = 7
) (
  input  logic        clk16x,
  input  logic        rst,
  uart_rcv_if.slave   bus
);
  localparam logic [3:0] SP = 4'(SAMPLE_PT);

  logic sdi_s, sdi_fall_unused, rdn_s_unused, rd_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sdi_sync (
    .clk(clk16x), .rst(rst), .d_i(bus.sdi), .q_o(sdi_s), .fall_o(sdi_fall_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_rdn_sync (
    .clk(clk16x), .rst(rst), .d_i(bus.rdn), .q_o(rdn_s_unused), .fall_o(rd_fall)
  );

  rcv_state_e           state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [2:0]           bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, dout_q, dout_d;
  logic                 par_q, par_d;
  logic                 rdy_q, rdy_d, ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 sample, wrap, done;

  always_ff @(posedge clk16x or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      par_q   <= PARITY_SEED;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign sample = (tick_q == SP);
  assign wrap   = (tick_q == TICK_MAX);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    par_d   = par_q;
    done    = 1'b0;
    if (state_q != IDLE && state_q != WAIT_HIGH) tick_d = tick_q + 4'd1;

    unique case (state_q)
      IDLE: if (!sdi_s) begin
        tick_d  = '0;
        state_d = START;
      end
      START: begin
        if (sample) begin
          if (sdi_s) state_d = IDLE;
          else begin
            bitn_d = '0;
            par_d  = PARITY_SEED;
          end
        end else if (wrap) state_d = DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d = {shift_q[DATA_BITS-2:0], sdi_s};
          par_d   = par_q ^ sdi_s;
        end
        if (wrap) begin
          bitn_d = bitn_q + 3'd1;
          if (bitn_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample) par_d = par_q ^ sdi_s;
        if (wrap) state_d = STOP;
      end
      STOP: if (sample) begin
        done    = 1'b1;
        state_d = sdi_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: if (sdi_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A read landing on the completion cycle consumed the old byte, so no overrun.
  always_comb begin
    dout_d = dout_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    rdy_d  = rdy_q;
    ovr_d  = ovr_q;
    if (done) begin
      dout_d = shift_q;
      perr_d = par_q;
      ferr_d = ~sdi_s;
      rdy_d  = 1'b1;
      ovr_d  = rd_fall ? 1'b0 : (ovr_q | rdy_q);
    end else if (rd_fall) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.data_ready    = rdy_q;
  assign bus.parity_error  = perr_q;
  assign bus.framing_error = ferr_q;
  assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_uart_rcv.sv
// Bench for uart_rcv: frames are driven bit-by-bit on sdi, expected results queued
// by the stimulus and checked by an independent monitor on each completion.
module tb_uart_rcv;
  localparam int SYNC_STAGES = 2;
  localparam int SAMPLE_PT   = 7;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic clk, rst;
  int   errors = 0, checks = 0;
  int   cyc = 0, t_start = 0, last_rise = -1;
  logic unread = 1'b0;
  exp_t expq[$];

  uart_rcv_if bus();
  uart_rcv #(.SYNC_STAGES(SYNC_STAGES), .SAMPLE_PT(SAMPLE_PT)) dut (
    .clk16x(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a completion shows as data_ready rising, or overrun rising while it is high.
  logic prev_dr = 1'b0, prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_dr = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if ((bus.data_ready && !prev_dr) || (bus.overrun && !prev_ov)) begin
        if (bus.data_ready && !prev_dr) last_rise = cyc;
        if (expq.size() == 0) begin
          chk("unexpected_frame", {24'h0, bus.dout}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("dout", {24'h0, bus.dout}, {24'h0, e.data});
          chk("parity_error", {31'h0, bus.parity_error}, {31'h0, e.perr});
          chk("framing_error", {31'h0, bus.framing_error}, {31'h0, e.ferr});
          chk("overrun", {31'h0, bus.overrun}, {31'h0, e.ovr});
          chk("data_ready", {31'h0, bus.data_ready}, 32'h1);
        end
      end
      prev_dr = bus.data_ready;
      prev_ov = bus.overrun;
    end
  end

  // Frame bits in line order: start, d7..d0, parity, stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pflip, input logic stop);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return {1'b0, d, p ^ pflip, stop};
  endfunction

  // Drives up to ncyc clocks of the frame; the line keeps its last value afterwards.
  task automatic line_out(input logic [10:0] frm, input int ncyc);
    int n = 0;
    for (int b = 10; b >= 0; b--) begin
      for (int t = 0; t < 16; t++) begin
        if (n == ncyc) return;
        @(negedge clk);
        if (n == 0) t_start = cyc;
        bus.sdi = frm[b];
        n++;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pflip, input logic stop);
    exp_t e;
    e.data = d; e.perr = pflip; e.ferr = ~stop; e.ovr = unread;
    expq.push_back(e);
    unread = 1'b1;
    line_out(mk_frame(d, pflip, stop), 176);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.sdi = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read();
    @(negedge clk);
    bus.rdn = 1'b0;
    repeat (4) @(negedge clk);
    bus.rdn = 1'b1;
    repeat (4) @(negedge clk);
    chk("read_clears_ready", {31'h0, bus.data_ready}, 32'h0);
    chk("read_clears_overrun", {31'h0, bus.overrun}, 32'h0);
    unread = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       pf, st, was_unread;
    int         gap, w;
    rst = 1'b1; bus.sdi = 1'b1; bus.rdn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'h0, bus.dout}, 32'h0);
    chk("rst_ready", {31'h0, bus.data_ready}, 32'h0);
    chk("rst_perr", {31'h0, bus.parity_error}, 32'h0);
    chk("rst_ferr", {31'h0, bus.framing_error}, 32'h0);
    chk("rst_ovr", {31'h0, bus.overrun}, 32'h0);
    rst = 1'b0;
    idle(10);

    // Completion lands 168 cycles after detect; detect is SYNC_STAGES edges after the pin is sampled.
    send(8'hA5, 1'b0, 1'b1);
    idle(4);
    chk("latency_A5", last_rise - t_start, 1 + SYNC_STAGES + 168);
    do_read();
    chk("dout_held_after_read", {24'h0, bus.dout}, 32'hA5);

    send(8'h3C, 1'b1, 1'b1);
    idle(4); do_read();
    send(8'h01, 1'b0, 1'b1);
    idle(4); do_read();

    // Stop low then line held low: only one frame may complete.
    send(8'h55, 1'b0, 1'b0);
    repeat (40 * 16) @(negedge clk);
    idle(20); do_read();
    send(8'h7E, 1'b0, 1'b1);
    idle(4); do_read();

    // Short glitch must not start a frame.
    @(negedge clk); bus.sdi = 1'b0;
    repeat (4) @(negedge clk); bus.sdi = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_ready", {31'h0, bus.data_ready}, 32'h0);

    // Back-to-back frames, no read in between.
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    idle(4);
    chk("b2b_dout", {24'h0, bus.dout}, 32'h22);
    do_read();

    // Reset mid-frame discards the partial byte.
    line_out(mk_frame(8'h99, 1'b0, 1'b1), 80);
    @(negedge clk); rst = 1'b1; bus.sdi = 1'b1;
    @(negedge clk);
    chk("midrst_dout", {24'h0, bus.dout}, 32'h0);
    chk("midrst_ready", {31'h0, bus.data_ready}, 32'h0);
    chk("midrst_perr", {31'h0, bus.parity_error}, 32'h0);
    chk("midrst_ferr", {31'h0, bus.framing_error}, 32'h0);
    chk("midrst_ovr", {31'h0, bus.overrun}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0; unread = 1'b0;
    idle(20);
    send(8'hC3, 1'b0, 1'b1);
    idle(4); do_read();

    // Randomized frames, errors, gaps and reads.
    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      was_unread = unread;
      send(d, pf, st);
      gap = st ? $urandom_range(0, 12) : $urandom_range(4, 20);
      if (gap > 0) idle(gap);
      if (was_unread || $urandom_range(0, 1) == 1) begin
        if (gap < 4) idle(4);
        do_read();
      end
    end
    idle(20);

    w = 0;
    while (expq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rcv.md
# uart_rcv

Serial receiver for the 16x-oversampled UART link; it is the far end of the existing transmitter's frame format. It runs on `clk16x` and hunts for a start bit on `sdi`, then recovers 8 data bits MSB-first, checks odd parity and the stop bit, and presents the byte on `dout`. A `data_ready`/`rdn` handshake hands the byte to the host bus, and errors are latched per frame. Frame: start (0), d7..d0, parity, stop (1); parity bit = 1 XOR d7..d0 (odd parity).

## Interface
- SYNC_STAGES, 2, flip-flop stages on `sdi` and `rdn` before use (min 2)
- SAMPLE_PT, 7, tick index (0..15) within each bit at which the line is sampled
- clk16x  input  1  16x bit-rate clock; the only clock
- rst  input  1  reset, asynchronous, active-high
- sdi  input  1  serial line, idle high, asynchronous to `clk16x`
- rdn  input  1  host read strobe, active-low, asynchronous; falling edge acknowledges the byte
- dout  output  8  last received byte, stable until the next frame completes
- data_ready  output  1  high from frame completion until acknowledged
- parity_error  output  1  parity check of the byte in `dout` failed
- framing_error  output  1  stop bit of the byte in `dout` sampled low
- overrun  output  1  a frame completed while `data_ready` was still high

## Operation
- `sdi` and `rdn` pass through SYNC_STAGES flops; all logic uses the synchronized versions `sdi_s` and `rdn_s`.
- 4-bit tick counter `tick`, 3-bit bit counter `bitn`, 8-bit shift register, running parity bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when `sdi_s`=0, clear `tick` and go to START.
- START: at `tick`==SAMPLE_PT, if `sdi_s`=1 the start was false; return to IDLE with nothing latched. Otherwise clear `bitn`, seed parity=1, go to DATA at the next `tick` wrap.
- DATA: sample at `tick`==SAMPLE_PT, shift left (first bit received lands in bit 7), parity ^= sample. After `bitn`==7, go to PARITY.
- PARITY: at sample point, parity ^= sample. Result 0 means OK; 1 means parity error.
- STOP: at sample point, complete the frame:
  - load `dout`, `parity_error`, `framing_error` (=!sample);
  - set `data_ready`, and set `overrun` if `data_ready` was already high.
  - If stop=1, go to IDLE; if stop=0, go to WAIT_HIGH.
- WAIT_HIGH: stay until `sdi_s`=1, then go to IDLE. This prevents a break or held-low line from being seen as a new start.
- Read: a falling edge of `rdn_s` (high→low) clears `data_ready` and `overrun`. `dout` and the error flags hold their values.
- Overrun policy: the new frame overwrites `dout` and the error flags; `overrun` stays latched until a read.
- `tick` counts 0..15 and wraps freely while not in IDLE/WAIT_HIGH; `bitn` wraps 7→0 on the DATA exit.

## Timing
- Reset values: `dout`=8'h00, `data_ready`=0, `parity_error`=0, `framing_error`=0, `overrun`=0, FSM=IDLE, sync flops=1.
- Start detect: the first `clk16x` edge on which `sdi_s`=0 in IDLE. Call it cycle 0.
- Sample instants:
  - start bit at cycle SAMPLE_PT;
  - data bit k (k=0 is d7) at SAMPLE_PT+16(k+1);
  - parity at SAMPLE_PT+144;
  - stop at SAMPLE_PT+160.
- Outputs update on the edge after the stop sample (cycle SAMPLE_PT+161 = 168 with defaults).
- Pin-to-detect latency is SYNC_STAGES cycles.
- A new start can be detected from the cycle after returning to IDLE, so back-to-back frames with one stop bit are received without loss.
- Read edge and frame completion on the same cycle: completion wins, so `data_ready`=1; `overrun` is not set because the read consumed the old byte.
- `rst` mid-frame: immediate return to reset values. A partially received byte is discarded.

## Structure
- Package `uart_pkg`: FSM state enum, `OVERSAMPLE`=16, `DATA_BITS`=8, `PARITY_SEED`=1'b1. These are shared with the transmitter.
- Sub-module `sync_edge`: SYNC_STAGES synchronizer with a falling-edge pulse output. It is instantiated twice, for `sdi` and `rdn`.
- The FSM, counters, shift register and output registers live in `uart_rcv`.

## Test plan
- Frame 8'hA5 (parity bit 1), stop 1 → `dout`=8'hA5, `data_ready`=1 at cycle 168 after detect, both error flags 0; an `rdn` pulse then clears `data_ready`.
- Frame 8'h3C with parity bit flipped to 0 → `dout`=8'h3C, `parity_error`=1; the next good frame 8'h01 clears it.
- Frame 8'h55 with stop=0, line held low for 40 bit times → `framing_error`=1, no further frames received; after the line returns high, 8'h7E is received correctly.
- Glitch: `sdi` low for 4 cycles only → FSM returns to IDLE, `data_ready` stays 0.
- Two back-to-back frames 8'h11 then 8'h22 with no read → `dout`=8'h22, `overrun`=1; an `rdn` falling edge clears both `data_ready` and `overrun`.
- `rst` asserted at cycle 80 of a frame, released, then frame 8'hC3 sent → all outputs at reset values during reset, then `dout`=8'hC3 with no errors.
